// File: rtl/synapse_mac_unit_pkg.sv
// Shared constants for the synapse MAC unit: FSM encoding, default sizes and
// the width helper used by the saturating adder.
package synapse_mac_unit_pkg;

  localparam int DEF_NUM_CONN = 8;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_WEIGHT_W = 32;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // One guard bit is enough to detect overflow of a two-operand signed add.
  function automatic int sat_sum_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/synapse_mac_unit_if.sv
// Configuration, spike and result signals of the synapse MAC unit.
interface synapse_mac_unit_if #(
  parameter int NUM_CONN = 8,
  parameter int ADDR_W   = 12,
  parameter int WEIGHT_W = 32
);
  localparam int IDX_W = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1;

  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic                cfg_en;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic                cfg_ready;
  logic                spike_valid;
  logic [ADDR_W-1:0]   spike_addr;
  logic                timestep_end;
  logic [WEIGHT_W-1:0] mac_out;
  logic                mac_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_weight,
    output spike_valid, spike_addr, timestep_end,
    input  cfg_ready, mac_out, mac_valid, busy, overrun
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_addr, cfg_weight,
    input  spike_valid, spike_addr, timestep_end,
    output cfg_ready, mac_out, mac_valid, busy, overrun
  );
endinterface

// File: rtl/synapse_mac_unit_sat_adder.sv
// Combinational signed adder that clamps to the representable range instead
// of wrapping.
module synapse_mac_unit_sat_adder
  import synapse_mac_unit_pkg::*;
#(
  parameter int W = DEF_WEIGHT_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  localparam int SUM_W = sat_sum_w(W);

  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(a) + SUM_W'(b);
    y   = sum[W-1:0];
    // Guard bit disagreeing with the result sign means overflow.
    if (sum[SUM_W-1] != sum[W-1]) begin
      y = sum[SUM_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/synapse_mac_unit.sv
// Per-neuron synapse accumulator: collects spikes against a connection table
// during a timestep, then sums the matched weights one entry per cycle.
module synapse_mac_unit
  import synapse_mac_unit_pkg::*;
#(
  parameter int NUM_CONN = DEF_NUM_CONN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic CLK,
  input  logic RST,
  synapse_mac_unit_if.slave bus
);
  localparam int IDX_W = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONN - 1);

  logic [1:0]                 state_q, state_d;
  logic [NUM_CONN-1:0]        en_q, en_d;
  logic [ADDR_W-1:0]          addr_q [NUM_CONN];
  logic [ADDR_W-1:0]          addr_d [NUM_CONN];
  logic signed [WEIGHT_W-1:0] weight_q [NUM_CONN];
  logic signed [WEIGHT_W-1:0] weight_d [NUM_CONN];
  logic [NUM_CONN-1:0]        incoming_q, incoming_d;
  logic [NUM_CONN-1:0]        pending_q, pending_d;
  logic [NUM_CONN-1:0]        match;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [WEIGHT_W-1:0] acc_q, acc_d;
  logic signed [WEIGHT_W-1:0] mac_out_q, mac_out_d;
  logic signed [WEIGHT_W-1:0] addend, sum;
  logic                       overrun_q, overrun_d;
  logic                       busy, cfg_wr;

  assign busy   = (state_q != ST_COLLECT);
  assign cfg_wr = bus.cfg_we && !busy && (32'(bus.cfg_idx) < NUM_CONN);

  // Every entry compares in parallel so duplicate addresses all fire at once.
  generate
    for (genvar gi = 0; gi < NUM_CONN; gi++) begin : g_match
      assign match[gi] = bus.spike_valid && en_q[gi] && (addr_q[gi] == bus.spike_addr);
    end
  endgenerate

  assign addend = pending_q[idx_q] ? weight_q[idx_q] : '0;

  synapse_mac_unit_sat_adder #(.W(WEIGHT_W)) u_sat_adder (
    .a (acc_q),
    .b (addend),
    .y (sum)
  );

  always_comb begin
    en_d     = en_q;
    addr_d   = addr_q;
    weight_d = weight_q;
    if (cfg_wr) begin
      en_d[bus.cfg_idx]     = bus.cfg_en;
      addr_d[bus.cfg_idx]   = bus.cfg_addr;
      weight_d[bus.cfg_idx] = bus.cfg_weight;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    mac_out_d  = mac_out_q;
    pending_d  = pending_q;
    incoming_d = incoming_q;
    overrun_d  = busy && bus.timestep_end;
    case (state_q)
      ST_COLLECT: begin
        if (bus.timestep_end) begin
          pending_d  = incoming_q;
          incoming_d = '0;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          mac_out_d = sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_COLLECT;
      default:  state_d = ST_COLLECT;
    endcase
    // Applied after the clear so a spike alongside timestep_end opens the new timestep.
    incoming_d = incoming_d | match;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_COLLECT;
      en_q       <= '0;
      incoming_q <= '0;
      pending_q  <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      mac_out_q  <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_CONN; i++) begin
        addr_q[i]   <= '0;
        weight_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      weight_q   <= weight_d;
      incoming_q <= incoming_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      mac_out_q  <= mac_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.cfg_ready = !busy;
  assign bus.busy      = busy;
  assign bus.mac_valid = (state_q == ST_DONE);
  assign bus.mac_out   = mac_out_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_synapse_mac_unit.sv
// Bench for synapse_mac_unit: directed scenarios plus random traffic, all
// checked every cycle against a timestep-level behavioural model.
module tb_synapse_mac_unit;
  localparam int NC = 8;
  localparam int AW = 12;
  localparam int WW = 32;
  localparam longint SMAX = (longint'(1) << (WW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (WW - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synapse_mac_unit_if #(.NUM_CONN(NC), .ADDR_W(AW), .WEIGHT_W(WW)) bus ();

  synapse_mac_unit #(.NUM_CONN(NC), .ADDR_W(AW), .WEIGHT_W(WW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: connection table, spike set of the open timestep, and the number of
  // cycles the unit still stays busy after a timestep was closed.
  bit          m_en   [NC];
  logic [AW-1:0] m_addr [NC];
  logic [WW-1:0] m_w    [NC];
  bit          m_inc  [NC];
  int          busy_left = 0;
  longint      m_result  = 0;
  logic [WW-1:0] exp_mac_out = '0;
  bit          exp_overrun = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit     match [NC];
    bit     was_busy;
    longint s;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_en[i] = 1'b0; m_addr[i] = '0; m_w[i] = '0; m_inc[i] = 1'b0;
      end
      busy_left   = 0;
      exp_mac_out = '0;
      exp_overrun = 1'b0;
      return;
    end
    was_busy    = (busy_left > 0);
    exp_overrun = was_busy && bus.timestep_end;
    for (int i = 0; i < NC; i++)
      match[i] = bus.spike_valid && m_en[i] && (m_addr[i] == bus.spike_addr);
    if (bus.cfg_we && !was_busy) begin
      m_en[bus.cfg_idx]   = bus.cfg_en;
      m_addr[bus.cfg_idx] = bus.cfg_addr;
      m_w[bus.cfg_idx]    = bus.cfg_weight;
    end
    if (!was_busy && bus.timestep_end) begin
      s = 0;
      for (int i = 0; i < NC; i++) begin
        if (m_inc[i]) begin
          s = s + longint'($signed(m_w[i]));
          if (s > SMAX) s = SMAX;
          if (s < SMIN) s = SMIN;
        end
        m_inc[i] = 1'b0;
      end
      m_result  = s;
      busy_left = NC + 1;
    end else if (was_busy) begin
      busy_left--;
      if (busy_left == 1) exp_mac_out = m_result[WW-1:0];
    end
    for (int i = 0; i < NC; i++)
      if (match[i]) m_inc[i] = 1'b1;
  endtask

  task automatic compare();
    check("busy", bus.busy, busy_left > 0);
    check("cfg_ready", bus.cfg_ready, !(busy_left > 0));
    check("mac_valid", bus.mac_valid, busy_left == 1);
    check("overrun", bus.overrun, exp_overrun);
    check("mac_out", $signed(bus.mac_out), $signed(exp_mac_out));
    if (bus.mac_valid)
      $display("cycle %0d result mac_out=%0d", cyc, $signed(bus.mac_out));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
    bus.cfg_addr = '0; bus.cfg_weight = '0;
    bus.spike_valid = 1'b0; bus.spike_addr = '0; bus.timestep_end = 1'b0;
  endtask

  task automatic do_cfg(input int idx, input bit en, input int addr, input logic [WW-1:0] w);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_en = en;
    bus.cfg_addr = AW'(addr); bus.cfg_weight = w;
    tick();
    idle();
  endtask

  task automatic do_spike(input int addr);
    bus.spike_valid = 1'b1; bus.spike_addr = AW'(addr);
    tick();
    idle();
  endtask

  task automatic wait_result(input string name, input longint lit, output int k);
    k = 0;
    while (!bus.mac_valid && k < 20) begin
      tick();
      k++;
    end
    if (!bus.mac_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: no mac_valid within 20 cycles, expected one", name);
    end else begin
      check(name, $signed(bus.mac_out), lit);
      check({name, "_model"}, $signed(exp_mac_out), lit);
    end
  endtask

  task automatic run_timestep(input string name, input longint lit);
    int k;
    bus.timestep_end = 1'b1;
    tick();
    bus.timestep_end = 1'b0;
    wait_result(name, lit, k);
    check({"latency_", name}, k + 1, 9);
    tick();
  endtask

  initial begin
    int k;
    int seen;
    idle();
    rst = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_mac_out", $signed(bus.mac_out), 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);

    do_cfg(0, 1, 0, 100);
    do_cfg(1, 1, 1, -30);
    do_cfg(2, 1, 2, 250);

    do_spike(0); do_spike(2);
    run_timestep("sum_350", 350);
    do_spike(1); do_spike(1); do_spike(7);
    run_timestep("sum_m30", -30);
    run_timestep("empty", 0);

    do_cfg(0, 1, 0, 32'h7FFFFFF0); do_cfg(1, 1, 1, 32'h7FFFFFF0);
    do_spike(0); do_spike(1);
    run_timestep("sat_pos", 64'h7FFFFFFF);
    do_cfg(0, 1, 0, 32'h80000010); do_cfg(1, 1, 1, 32'h80000010);
    do_spike(0); do_spike(1);
    run_timestep("sat_neg", -64'sd2147483648);
    do_cfg(0, 1, 0, 100); do_cfg(1, 1, 1, -30);

    // Spike together with the closing pulse, then a premature second close.
    bus.timestep_end = 1'b1; bus.spike_valid = 1'b1; bus.spike_addr = AW'(2);
    tick();
    idle();
    tick(); tick();
    bus.timestep_end = 1'b1;
    tick();
    bus.timestep_end = 1'b0;
    check("overrun_pulse", bus.overrun, 1);
    tick();
    check("overrun_clear", bus.overrun, 0);
    wait_result("ovr_first", 0, k);
    check("latency_ovr", k + 5, 9);
    tick();
    run_timestep("ovr_next", 250);

    // Table write attempted while accumulating must be dropped.
    bus.timestep_end = 1'b1;
    tick();
    bus.timestep_end = 1'b0;
    tick();
    do_cfg(0, 1, 0, 999);
    wait_result("busy_cfg_empty", 0, k);
    tick();
    do_spike(0);
    run_timestep("cfg_ignored", 100);

    // Reset in the middle of accumulation aborts the timestep.
    do_spike(0);
    bus.timestep_end = 1'b1;
    tick();
    bus.timestep_end = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_mac_out", $signed(bus.mac_out), 0);
    seen = 0;
    repeat (15) begin
      tick();
      if (bus.mac_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    do_spike(0);
    run_timestep("after_rst_empty", 0);

    for (int i = 0; i < NC; i++)
      do_cfg(i, 1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom);
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.cfg_we = ($urandom_range(0, 5) == 0);
      bus.cfg_idx = 3'($urandom_range(0, NC - 1));
      bus.cfg_en = 1'($urandom_range(0, 3) != 0);
      bus.cfg_addr = AW'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       bus.cfg_weight = 32'h7FFFFFF0;
        1:       bus.cfg_weight = 32'h80000010;
        2:       bus.cfg_weight = WW'($urandom_range(0, 2000)) - WW'(1000);
        default: bus.cfg_weight = $urandom;
      endcase
      bus.spike_valid = 1'($urandom_range(0, 1));
      bus.spike_addr = AW'($urandom_range(0, 6));
      bus.timestep_end = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
